// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with a one-word skid buffer.
// Feeds a downstream sequence detector with a gap-free stream of word bits.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic [15:0]      words_sent
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_next;
    logic             hold_full;
    logic             hold_full_next;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_next;
    logic [15:0]      sent_cnt;
    logic             xfer;
    logic             last;
    logic [WIDTH-1:0] shreg_adv;

    assign din_ready  = ~hold_full & ~reset;
    assign xfer       = din_valid & din_ready;
    assign last       = (state == SHIFT) && (bit_cnt == LAST);
    assign x_valid    = (state == SHIFT);
    assign x          = x_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign word_done  = last;
    assign words_sent = sent_cnt;
    assign shreg_adv  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath: direct load when the shifter frees up, else park in hold
    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        hold_next      = hold;
        hold_full_next = hold_full;
        bit_cnt_next   = bit_cnt;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_next   = SHIFT;
                    shreg_next   = din;
                    bit_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    bit_cnt_next = '0;
                    if (hold_full) begin
                        shreg_next     = hold;
                        hold_full_next = 1'b0;
                    end else if (xfer) begin
                        shreg_next = din;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CW'(1);
                    shreg_next   = shreg_adv;
                    if (xfer) begin
                        hold_next      = din;
                        hold_full_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; reset drops any partial or parked word
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            shreg     <= shreg_next;
            hold      <= hold_next;
            hold_full <= hold_full_next;
            bit_cnt   <= bit_cnt_next;
        end
    end

    // Completed-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt <= '0;
        end else if (word_done) begin
            sent_cnt <= sent_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed vector table, corner sequences and a
// randomized run against a bit-queue reference model.
module tb_bit_serializer;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        x;
    logic        x_valid;
    logic        word_done;
    logic [15:0] words_sent;

    logic [7:0]  din_l;
    logic        din_valid_l;
    logic        din_ready_l;
    logic        x_l;
    logic        x_valid_l;
    logic        word_done_l;
    logic [15:0] words_sent_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running clock
    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .word_done  (word_done),
        .words_sent (words_sent)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .din        (din_l),
        .din_valid  (din_valid_l),
        .din_ready  (din_ready_l),
        .x          (x_l),
        .x_valid    (x_valid_l),
        .word_done  (word_done_l),
        .words_sent (words_sent_l)
    );

    typedef struct {
        logic [7:0]  din;
        logic        v;
        logic        x;
        logic        xv;
        logic        wd;
        logic        rdy;
        logic [15:0] ws;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic [7:0] d, logic v, logic ex, logic exv,
                                logic ewd, logic erdy, logic [15:0] ews);
        vec_t r;
        r.din = d;
        r.v   = v;
        r.x   = ex;
        r.xv  = exv;
        r.wd  = ewd;
        r.rdy = erdy;
        r.ws  = ews;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset       = 1'b1;
        din_valid   = 1'b1;
        din         = 8'hC3;
        din_valid_l = 1'b0;
        din_l       = 8'h00;
        next_cycle();
        @(negedge clk);
        check("rst_ready", din_ready, 0);
        check("rst_x", x, 0);
        check("rst_xv", x_valid, 0);
        check("rst_wd", word_done, 0);
        check("rst_ws", words_sent, 0);
        next_cycle();
        reset     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("rst_rel_ready", din_ready, 1);
        check("rst_rel_xv", x_valid, 0);
        next_cycle();
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] pc;
        bit         q[$];
        int         ws_m;
        int         accepted;
        int         cycles;
        logic       e_rdy;
        logic       e_xv;
        logic       e_x;
        logic       e_wd;

        pa = 8'b0010_0110;
        pb = 8'hA5;
        pc = 8'h3C;
        tbl[0] = mk(pa, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            tbl[1+i] = mk(0, 0, pa[7-i], 1, i == 7, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 1);
        tbl[10] = mk(pb, 1, 0, 0, 0, 1, 1);
        tbl[11] = mk(pc, 1, pb[7], 1, 0, 1, 1);
        for (int i = 1; i < 8; i++)
            tbl[11+i] = mk(0, 0, pb[7-i], 1, i == 7, 0, 1);
        for (int i = 0; i < 8; i++)
            tbl[19+i] = mk(0, 0, pc[7-i], 1, i == 7, 1, 2);
        tbl[27] = mk(0, 0, 0, 0, 0, 1, 3);

        do_reset();

        for (int i = 0; i < 28; i++) begin
            din       = tbl[i].din;
            din_valid = tbl[i].v;
            @(negedge clk);
            check($sformatf("tbl[%0d].x", i), x, tbl[i].x);
            check($sformatf("tbl[%0d].xv", i), x_valid, tbl[i].xv);
            check($sformatf("tbl[%0d].wd", i), word_done, tbl[i].wd);
            check($sformatf("tbl[%0d].rdy", i), din_ready, tbl[i].rdy);
            check($sformatf("tbl[%0d].ws", i), words_sent, tbl[i].ws);
            next_cycle();
        end

        din_l       = 8'h01;
        din_valid_l = 1'b1;
        @(negedge clk);
        check("lsb_ready", din_ready_l, 1);
        check("lsb_idle_xv", x_valid_l, 0);
        next_cycle();
        din_valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("lsb_x[%0d]", i), x_l, i == 0);
            check($sformatf("lsb_xv[%0d]", i), x_valid_l, 1);
            check($sformatf("lsb_wd[%0d]", i), word_done_l, i == 7);
            next_cycle();
        end
        @(negedge clk);
        check("lsb_end_xv", x_valid_l, 0);
        check("lsb_end_ws", words_sent_l, 1);
        next_cycle();

        din       = 8'hFF;
        din_valid = 1'b1;
        next_cycle();
        din = 8'h00;
        @(negedge clk);
        check("mid_hold_ready", din_ready, 1);
        next_cycle();
        din_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid_bit%0d_ready", i), din_ready, 0);
            check($sformatf("mid_bit%0d_wd", i), word_done, 0);
            next_cycle();
        end
        reset     = 1'b1;
        din       = 8'h55;
        din_valid = 1'b1;
        @(negedge clk);
        check("mid_b3_x", x, 1);
        check("mid_b3_xv", x_valid, 1);
        check("mid_b3_ready", din_ready, 0);
        check("mid_b3_wd", word_done, 0);
        next_cycle();
        @(negedge clk);
        check("mid_rst_x", x, 0);
        check("mid_rst_xv", x_valid, 0);
        check("mid_rst_ready", din_ready, 0);
        check("mid_rst_ws", words_sent, 0);
        check("mid_rst_wd", word_done, 0);
        next_cycle();
        reset     = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("mid_post%0d_xv", i), x_valid, 0);
            check($sformatf("mid_post%0d_ready", i), din_ready, 1);
            check($sformatf("mid_post%0d_wd", i), word_done, 0);
            next_cycle();
        end

        force dut.sent_cnt = 16'hFFFF;
        next_cycle();
        release dut.sent_cnt;
        @(negedge clk);
        check("wrap_preload", words_sent, 16'hFFFF);
        next_cycle();
        din       = 8'h5A;
        din_valid = 1'b1;
        next_cycle();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("wrap_ws%0d", i), words_sent, 16'hFFFF);
            next_cycle();
        end
        @(negedge clk);
        check("wrap_ws_after", words_sent, 16'h0000);
        next_cycle();

        do_reset();
        ws_m     = 0;
        accepted = 0;
        cycles   = 0;
        while ((accepted < 1000 || q.size() != 0) && cycles < 40000) begin
            din       = 8'($urandom);
            din_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            e_rdy = (q.size() <= W);
            e_xv  = (q.size() != 0);
            e_x   = e_xv ? q[0] : 1'b0;
            e_wd  = e_xv && ((q.size() % W) == 1);
            @(negedge clk);
            check("rnd_ready", din_ready, e_rdy);
            check("rnd_xv", x_valid, e_xv);
            check("rnd_x", x, e_x);
            check("rnd_wd", word_done, e_wd);
            check("rnd_ws", words_sent, ws_m[15:0]);
            if (e_wd)
                ws_m++;
            if (e_xv)
                void'(q.pop_front());
            if (din_valid && e_rdy) begin
                for (int b = W - 1; b >= 0; b--)
                    q.push_back(din[b]);
                accepted++;
            end
            next_cycle();
            cycles++;
        end
        din_valid = 1'b0;
        check("rnd_in_budget", cycles < 40000, 1);
        check("rnd_accepted", accepted, 1000);
        @(negedge clk);
        check("rnd_final_ws", words_sent, ws_m[15:0]);
        check("rnd_final_xv", x_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
